// File: rtl/debug_state_streamer.sv
// Snapshots the core's register bank and data memory on i_start and streams
// the image out big-endian, one byte per valid/ready transfer.
//
// Ports:
//   i_clk, i_reset   clock, synchronous active-high reset
//   i_start          snapshot + stream request, honoured only when idle
//   i_registers      flattened register bank, reg k at [k*DATA_BUS_SIZE +: DATA_BUS_SIZE]
//   i_mem_data       flattened data memory, same packing
//   i_ready          downstream accepts o_data this cycle
//   o_data, o_valid  stream byte and its qualifier
//   o_busy           high while streaming
//   o_done           one-cycle pulse after the last byte is accepted
module debug_state_streamer #(
  parameter int DATA_BUS_SIZE         = 32,
  parameter int REGISTERS_BANK_SIZE   = 32,
  parameter int DATA_MEMORY_ADDR_SIZE = 5,
  parameter int BYTE_SIZE             = 8
) (
  input  logic                                                 i_clk,
  input  logic                                                 i_reset,
  input  logic                                                 i_start,
  input  logic [REGISTERS_BANK_SIZE*DATA_BUS_SIZE-1:0]         i_registers,
  input  logic [(2**DATA_MEMORY_ADDR_SIZE)*DATA_BUS_SIZE-1:0]  i_mem_data,
  input  logic                                                 i_ready,
  output logic [BYTE_SIZE-1:0]                                 o_data,
  output logic                                                 o_valid,
  output logic                                                 o_busy,
  output logic                                                 o_done
);

  localparam int MEM_WORDS   = 2**DATA_MEMORY_ADDR_SIZE;
  localparam int TOTAL_WORDS = REGISTERS_BANK_SIZE + MEM_WORDS;
  localparam int BPW         = DATA_BUS_SIZE / BYTE_SIZE;
  localparam int SNAP_W      = TOTAL_WORDS * DATA_BUS_SIZE;
  localparam int WORD_W      = (TOTAL_WORDS > 1) ? $clog2(TOTAL_WORDS) : 1;
  localparam int BYTE_W      = (BPW > 1) ? $clog2(BPW) : 1;

  localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(TOTAL_WORDS - 1);
  localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(BPW - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [WORD_W-1:0]   word_q, word_d;
  logic [BYTE_W-1:0]   byte_q, byte_d;
  logic [SNAP_W-1:0]   snap_q, snap_d;

  logic                xfer;
  logic                last_byte;
  logic [DATA_BUS_SIZE-1:0] words [TOTAL_WORDS];
  logic [BYTE_SIZE-1:0]     bytes_of [BPW];
  logic [DATA_BUS_SIZE-1:0] cur_word;
  logic [BYTE_SIZE-1:0]     cur_byte;

  // Registers occupy the low words, memory follows, so the stream order is
  // simply word index 0..TOTAL_WORDS-1.
  always_comb begin
    for (int k = 0; k < TOTAL_WORDS; k++) begin
      words[k] = snap_q[k*DATA_BUS_SIZE +: DATA_BUS_SIZE];
    end
    cur_word = words[word_q];
    // Byte index 0 is the most significant byte of the word.
    for (int b = 0; b < BPW; b++) begin
      bytes_of[b] = cur_word[(BPW-1-b)*BYTE_SIZE +: BYTE_SIZE];
    end
    cur_byte = bytes_of[byte_q];
  end

  assign xfer      = (state_q == S_SEND) && i_ready;
  assign last_byte = (word_q == LAST_WORD) && (byte_q == LAST_BYTE);

  // State and counter registers.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= S_IDLE;
      word_q  <= '0;
      byte_q  <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      byte_q  <= byte_d;
    end
  end

  // Snapshot storage is pure datapath; its contents only matter in SEND.
  always_ff @(posedge i_clk) begin
    snap_q <= snap_d;
  end

  // Next-state and counter logic.
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    byte_d  = byte_q;
    snap_d  = snap_q;
    unique case (state_q)
      S_IDLE: begin
        if (i_start) begin
          snap_d  = {i_mem_data, i_registers};
          word_d  = '0;
          byte_d  = '0;
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        if (xfer) begin
          if (last_byte) begin
            word_d  = '0;
            byte_d  = '0;
            state_d = S_DONE;
          end else if (byte_q == LAST_BYTE) begin
            byte_d = '0;
            word_d = word_q + 1'b1;
          end else begin
            byte_d = byte_q + 1'b1;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs.
  always_comb begin
    o_valid = 1'b0;
    o_busy  = 1'b0;
    o_done  = 1'b0;
    o_data  = '0;
    unique case (state_q)
      S_IDLE: begin
      end
      S_SEND: begin
        o_valid = 1'b1;
        o_busy  = 1'b1;
        o_data  = cur_byte;
      end
      S_DONE: begin
        o_done = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule
